serial_adder_n: RTL and testbench
=================================

Name: serial_adder_n

Overview:
- Parametrised multi-cycle adder/subtractor. Processes two WIDTH-bit operands DIGIT bits per clock.
- The combinational datapath is a DIGIT-bit ripple slice of full-adder cells. A carry register links successive digits.
- Start/busy/done handshake, so arithmetic units can trade area for latency.
- Reports sum, carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of DIGIT.
- DIGIT, 4, bits added per clock. 1 ≤ DIGIT ≤ WIDTH.
- N (derived localparam), WIDTH/DIGIT, number of RUN cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request a new operation; sampled only in IDLE
- mode  in  1  0 = add (a+b+cin), 1 = subtract (a-b; cin ignored)
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- cin  in  1  carry-in for add mode, captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when results update
- sum  out  WIDTH  result, held until next completion
- cout  out  1  carry out of MSB; in subtract mode 1 = no borrow
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, sum, cout, ovf, internal shift/carry/counter registers = 0.
  - Reset mid-RUN aborts the operation. No done pulse follows.
- States: IDLE, RUN.
  - IDLE→RUN on an edge with start=1.
  - RUN→IDLE on the edge completing digit N-1.
  - No other transitions.
- Accept edge (IDLE, start=1):
  - Load opA=a.
  - Load opB=b (mode=0) or ~b (mode=1).
  - Load carry=cin (mode=0) or 1 (mode=1).
  - Digit counter=0. busy=1 from next cycle.
- Each RUN edge k (k=0..N-1):
  - The slice adds opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - Slice sum enters the top DIGIT bits of the result shift register, which shifts right by DIGIT.
  - opA and opB shift right by DIGIT. carry takes the slice carry-out. Counter increments.
- Completion (edge k=N-1), all from the following cycle:
  - sum is loaded with the completed result.
  - cout = slice carry-out.
  - ovf = slice carry into bit DIGIT-1 XOR slice carry-out.
  - done=1 for exactly one cycle; busy=0.
- Latency: done is visible N cycles after the accept edge (N=1 when DIGIT=WIDTH).
- start while busy: ignored, with no queuing and no effect on the operation in flight. a/b/mode/cin changes during RUN have no effect.
- start high in the done cycle: accepted (state is IDLE). Back-to-back throughput is one result per N+1 cycles.
- sum/cout/ovf change only at completion or reset. They are stable while busy.
- All arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1.

Decomposition:
- Shared package/header holds:
  - state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1
  - mode constants MODE_ADD=0, MODE_SUB=1
- Sub-module fa_slice #(DIGIT): combinational DIGIT-bit ripple adder chained from the existing FA cell. Outputs s, co and c_msb_in (carry into its top bit).
- Top level holds only FSM, counter, shift registers and output registers.

Test Plan:
1. WIDTH=16, DIGIT=4: start, mode=0, a=0x1234, b=0x4321, cin=0 → done exactly 4 cycles after accept edge; sum=0x5555, cout=0, ovf=0; busy high for 4 cycles.
2. Add carry/overflow cases:
   - 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, ovf=0.
   - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
   - 0x0000+0x0000, cin=1 → sum=0x0001.
3. Subtract cases:
   - mode=1, 0x0005-0x0007 → sum=0xFFFE, cout=0, ovf=0.
   - 0x8000-0x0001 → sum=0x7FFF, cout=1, ovf=1.
   - Drive cin=1 during subtracts → result unchanged.
4. Handshake:
   - Start 0x0001+0x0001, then pulse start with a=0xFFFF on RUN cycle 2 → sum=0x0002, single done.
   - Assert start in the done cycle with 0x0010+0x0020 → second done N+1 cycles after the first, sum=0x0030.
5. Assert rst for 1 cycle mid-RUN (cycle 2) → immediately busy=0, sum=0, cout=0, ovf=0, no done. The next operation 0x00FF+0x0001 yields sum=0x0100 correctly.
6. Parameter sweep (DIGIT=1, 4, 16 at WIDTH=16; WIDTH=8, DIGIT=2):
   - Random operands/modes checked against a reference model.
   - Latency = WIDTH/DIGIT in every configuration.

Source files
------------

// File: rtl/serial_adder_n_pkg.sv
// Shared constants for the digit-serial adder: FSM state encoding and operation modes.
package serial_adder_n_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_n_fa_slice.sv
// Full-adder cell and the DIGIT-bit ripple slice built by chaining it.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module fa_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // c[i] is the carry into bit i; c[DIGIT] leaves the slice.
  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    fa_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co       = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: adds two WIDTH-bit operands DIGIT bits per clock.
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] slice_s;
  logic             slice_co;
  logic             slice_c_msb;
  logic [WIDTH-1:0] res_next;

  fa_slice #(.DIGIT(DIGIT)) u_slice (
    .a        (op_a[DIGIT-1:0]),
    .b        (op_b[DIGIT-1:0]),
    .ci       (carry),
    .s        (slice_s),
    .co       (slice_co),
    .c_msb_in (slice_c_msb)
  );

  // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
  assign res_next = (res_sh >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= (mode == MODE_SUB) ? ~b : b;
            carry <= (mode == MODE_SUB) ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          op_a   <= op_a >> DIGIT;
          op_b   <= op_b >> DIGIT;
          carry  <= slice_co;
          res_sh <= res_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= res_next;
            cout  <= slice_co;
            ovf   <= slice_c_msb ^ slice_co;
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench: directed handshake/arithmetic vectors plus a parameter sweep.
module tb_serial_adder_n;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        s_start = 1'b0;
  logic        s_mode = 1'b0;
  logic [15:0] s_a = '0;
  logic [15:0] s_b = '0;
  logic        s_cin = 1'b0;
  logic        x1_busy, x1_done, x1_cout, x1_ovf;
  logic [15:0] x1_sum;
  logic        x16_busy, x16_done, x16_cout, x16_ovf;
  logic [15:0] x16_sum;
  logic        x8_busy, x8_done, x8_cout, x8_ovf;
  logic [7:0]  x8_sum;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_n #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder_n #(.WIDTH(16), .DIGIT(1)) u_x1 (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .a(s_a), .b(s_b), .cin(s_cin),
    .busy(x1_busy), .done(x1_done), .sum(x1_sum), .cout(x1_cout), .ovf(x1_ovf)
  );

  serial_adder_n #(.WIDTH(16), .DIGIT(16)) u_x16 (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .a(s_a), .b(s_b), .cin(s_cin),
    .busy(x16_busy), .done(x16_done), .sum(x16_sum), .cout(x16_cout), .ovf(x16_ovf)
  );

  serial_adder_n #(.WIDTH(8), .DIGIT(2)) u_x8 (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .a(s_a[7:0]), .b(s_b[7:0]), .cin(s_cin),
    .busy(x8_busy), .done(x8_done), .sum(x8_sum), .cout(x8_cout), .ovf(x8_ovf)
  );

  // Reference arithmetic: returns {ovf, cout, sum} for a w-bit add or subtract.
  function automatic logic [17:0] ref_calc(input int w, input logic md, input logic [15:0] x,
                                           input logic [15:0] y, input logic ci);
    longint unsigned mask, xa, yb, full;
    logic [15:0] s;
    logic co, ov;
    mask = (64'd1 << w) - 64'd1;
    xa   = 64'(x) & mask;
    yb   = 64'(md ? ~y : y) & mask;
    full = xa + yb + 64'(md ? 1'b1 : ci);
    s    = 16'(full & mask);
    co   = full[w];
    ov   = (xa[w-1] == yb[w-1]) && (s[w-1] != xa[w-1]);
    return {ov, co, s};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Transaction-level model of the main instance: accept, wait N edges, publish.
  logic        m_busy = 1'b0, m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
  logic [15:0] m_sum = '0;
  logic [17:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_sum  <= m_pend[15:0];
          m_cout <= m_pend[16];
          m_ovf  <= m_pend[17];
        end
      end else if (start) begin
        m_pend <= ref_calc(16, mode, a, b, cin);
        m_left <= N;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("mon_busy", 32'(busy), 32'(m_busy));
      checkOutput("mon_done", 32'(done), 32'(m_done));
      checkOutput("mon_sum", 32'(sum), 32'(m_sum));
      checkOutput("mon_cout", 32'(cout), 32'(m_cout));
      checkOutput("mon_ovf", 32'(ovf), 32'(m_ovf));
      if (done) done_cnt++;
    end
  end

  task automatic waitDone(output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input string name, input logic md, input logic [15:0] x,
                               input logic [15:0] y, input logic ci, input logic [15:0] es,
                               input logic ec, input logic eo);
    int acc, at;
    bit ok;
    @(posedge clk);
    #1 start = 1'b1; mode = md; a = x; b = y; cin = ci;
    @(posedge clk);
    #1 start = 1'b0;
    acc = cyc;
    waitDone(at, ok);
    checkOutput({name, "_seen"}, 32'(ok), 32'd1);
    checkOutput({name, "_latency"}, 32'(at - acc), 32'(N));
    checkOutput({name, "_sum"}, 32'(sum), 32'(es));
    checkOutput({name, "_cout"}, 32'(cout), 32'(ec));
    checkOutput({name, "_ovf"}, 32'(ovf), 32'(eo));
    checkOutput({name, "_model_sum"}, 32'(m_sum), 32'(es));
    checkOutput({name, "_model_flags"}, 32'({m_cout, m_ovf}), 32'({ec, eo}));
  endtask

  initial begin
    int t1, t2, d0, acc;
    bit ok1, ok2;
    bit seen1, seen16, seen8;
    logic [17:0] r;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_res", 32'({sum, cout, ovf}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus("add_basic", 1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    applyStimulus("add_wrap",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("add_ovf",   1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    applyStimulus("add_cin",   1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    applyStimulus("sub_neg",   1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    applyStimulus("sub_ovf",   1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    applyStimulus("sub_cin1",  1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    applyStimulus("sub_cin1b", 1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Start pulse during RUN must be ignored entirely.
    @(posedge clk);
    #1 start = 1'b1; mode = 1'b0; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1'b1; a = 16'hFFFF;
    @(posedge clk);
    #1 start = 1'b0; a = 16'h0001;
    repeat (3 * N) @(negedge clk);
    checkOutput("busy_start_dones", 32'(done_cnt - d0), 32'd1);
    checkOutput("busy_start_sum", 32'(sum), 32'h0002);

    // Back-to-back: new start presented in the done cycle.
    @(posedge clk);
    #1 start = 1'b1; a = 16'h0003; b = 16'h0004;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(t1, ok1);
    checkOutput("b2b_first_sum", 32'(sum), 32'h0007);
    start = 1'b1; a = 16'h0010; b = 16'h0020;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(t2, ok2);
    checkOutput("b2b_seen", 32'({ok1, ok2}), 32'd3);
    checkOutput("b2b_spacing", 32'(t2 - t1), 32'(N + 1));
    checkOutput("b2b_sum", 32'(sum), 32'h0030);

    // Reset mid-RUN aborts with no later done.
    @(posedge clk);
    #1 start = 1'b1; a = 16'hAAAA; b = 16'h1111;
    @(posedge clk);
    #1 start = 1'b0;
    d0 = done_cnt;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_flags", 32'({cout, ovf}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * N) @(negedge clk);
    checkOutput("rst_no_done", 32'(done_cnt - d0), 32'd0);
    applyStimulus("after_rst", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Parameter sweep on the three extra configurations.
    for (int it = 0; it < 8; it++) begin
      @(posedge clk);
      #1 s_start = 1'b1; s_mode = 1'($urandom_range(0, 1));
      s_a = 16'($urandom); s_b = 16'($urandom); s_cin = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1 s_start = 1'b0;
      acc = cyc;
      seen1 = 1'b0; seen16 = 1'b0; seen8 = 1'b0;
      for (int k = 0; k < 40 && !(seen1 && seen16 && seen8); k++) begin
        @(negedge clk);
        if (x1_done && !seen1) begin
          seen1 = 1'b1;
          r = ref_calc(16, s_mode, s_a, s_b, s_cin);
          checkOutput("sweep_d1_latency", 32'(cyc - acc), 32'd16);
          checkOutput("sweep_d1_res", 32'({x1_ovf, x1_cout, x1_sum}), 32'(r));
        end
        if (x16_done && !seen16) begin
          seen16 = 1'b1;
          r = ref_calc(16, s_mode, s_a, s_b, s_cin);
          checkOutput("sweep_d16_latency", 32'(cyc - acc), 32'd1);
          checkOutput("sweep_d16_res", 32'({x16_ovf, x16_cout, x16_sum}), 32'(r));
        end
        if (x8_done && !seen8) begin
          seen8 = 1'b1;
          r = ref_calc(8, s_mode, s_a, s_b, s_cin);
          checkOutput("sweep_w8_latency", 32'(cyc - acc), 32'd4);
          checkOutput("sweep_w8_res", 32'({x8_ovf, x8_cout, x8_sum}), 32'({r[17:16], r[7:0]}));
        end
      end
      checkOutput("sweep_all_done", 32'({seen1, seen16, seen8}), 32'd7);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
